// File: rtl/rvr32_mdu_pkg.sv
// Shared encodings and helpers for the RV32M/RV64M multiply-divide unit.
// Op codes mirror funct3; state codes are exported through dbg_state.
package rvr32_mdu_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_signed_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/rvr32_mdu_div.sv
// Iterative radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
// done is high during the final iteration; quotient/remainder are valid after that edge.
module rvr32_mdu_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            abort,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CW = $clog2(XLEN + 1);

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] dvsr;
    logic [XLEN:0]   trial;
    logic [XLEN:0]   diff;

    always_comb begin
        trial = {remainder, quotient[XLEN-1]};
        diff  = trial - {1'b0, dvsr};
        done  = busy & (cnt == CW'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            cnt       <= '0;
            dvsr      <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (start) begin
            busy      <= 1'b1;
            cnt       <= CW'(XLEN);
            dvsr      <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (busy) begin
            // Borrow out of the trial subtraction means the divisor did not fit.
            if (!diff[XLEN]) begin
                remainder <= diff[XLEN-1:0];
                quotient  <= {quotient[XLEN-2:0], 1'b1};
            end else begin
                remainder <= trial[XLEN-1:0];
                quotient  <= {quotient[XLEN-2:0], 1'b0};
            end
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/rvr32_mdu.sv
// RV32M/RV64M multiply-divide unit: pipelined multiply, iterative divide, one op in flight.
// Handshake: a transfer happens on a rising edge where valid & ready; out_valid holds data until out_ready.
module rvr32_mdu
    import rvr32_mdu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [2:0]       dbg_state
);
    localparam int MD = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]      state;
    logic [2:0]      mul_cnt;
    logic [XLEN-1:0] mul_pipe [MD];
    logic            neg_q, neg_r, rem_sel;
    logic            accept, div_start, div_busy, div_done;
    logic [XLEN-1:0] div_q, div_r;

    logic              a_sx, b_sx;
    logic [2*XLEN-1:0] a_w, b_w, prod;
    logic [XLEN-1:0]   mul_res;

    // Operands are extended to 2*XLEN so a plain modular multiply yields the signed product.
    always_comb begin
        a_sx    = (in_op != OP_MULHU) & in_a[XLEN-1];
        b_sx    = ((in_op == OP_MUL) || (in_op == OP_MULH)) & in_b[XLEN-1];
        a_w     = {{XLEN{a_sx}}, in_a};
        b_w     = {{XLEN{b_sx}}, in_b};
        prod    = a_w * b_w;
        mul_res = (in_op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    logic            sdiv, a_neg, b_neg, div_zero, div_ovf, special;
    logic [XLEN-1:0] a_mag, b_mag, spec_res, fix_res;

    always_comb begin
        sdiv     = is_signed_div(in_op);
        a_neg    = sdiv & in_a[XLEN-1];
        b_neg    = sdiv & in_b[XLEN-1];
        a_mag    = a_neg ? -in_a : in_a;
        b_mag    = b_neg ? -in_b : in_b;
        div_zero = (in_b == '0);
        div_ovf  = sdiv & (in_a == MOST_NEG) & (in_b == '1);
        special  = div_zero | div_ovf;
        if (is_rem(in_op)) spec_res = div_zero ? in_a : '0;
        else               spec_res = div_zero ? '1 : in_a;
        if (rem_sel) fix_res = neg_r ? -div_r : div_r;
        else         fix_res = neg_q ? -div_q : div_q;
    end

    assign in_ready  = !flush && !div_busy &&
                       ((state == S_IDLE) || ((state == S_DONE) && out_ready));
    assign accept    = in_valid & in_ready;
    assign div_start = accept & is_div(in_op) & !special;
    assign out_valid = (state == S_DONE);
    assign dbg_state = state;

    rvr32_mdu_div #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (flush),
        .start     (div_start),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MD; i++) mul_pipe[i] <= '0;
        end else begin
            if (accept) mul_pipe[0] <= mul_res;
            for (int i = 1; i < MD; i++) mul_pipe[i] <= mul_pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mul_cnt  <= '0;
            out_data <= '0;
            out_tag  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            rem_sel  <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        out_tag <= in_tag;
                        if (!is_div(in_op)) begin
                            if (MUL_LAT == 1) begin
                                state    <= S_DONE;
                                out_data <= mul_res;
                            end else begin
                                state   <= S_MUL;
                                mul_cnt <= 3'(MUL_LAT - 1);
                            end
                        end else if (special) begin
                            state    <= S_DONE;
                            out_data <= spec_res;
                        end else begin
                            state   <= S_DIV;
                            neg_q   <= a_neg ^ b_neg;
                            neg_r   <= a_neg;
                            rem_sel <= is_rem(in_op);
                        end
                    end else if (state == S_DONE && out_ready) begin
                        state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    if (mul_cnt == 3'd1) begin
                        state    <= S_DONE;
                        out_data <= mul_pipe[MD-1];
                    end
                    mul_cnt <= mul_cnt - 3'd1;
                end
                S_DIV: begin
                    if (div_done) state <= S_FIX;
                end
                S_FIX: begin
                    state    <= S_DONE;
                    out_data <= fix_res;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvr32_mdu.sv
// Self-checking bench for rvr32_mdu (XLEN=32, MUL_LAT=2) with a data/tag/latency scoreboard.
module tb_rvr32_mdu;
    localparam int XLEN = 32;
    localparam int MUL_LAT = 2;
    localparam int TAG_W = 5;

    localparam logic [2:0] T_MUL = 3'd0, T_MULH = 3'd1, T_MULHSU = 3'd2, T_MULHU = 3'd3;
    localparam logic [2:0] T_DIV = 3'd4, T_DIVU = 3'd5, T_REM = 3'd6, T_REMU = 3'd7;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_DIV = 3'd2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [2:0] in_op = '0;
    logic [XLEN-1:0] in_a = '0, in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic in_ready, out_valid;
    logic [XLEN-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic [2:0] dbg_state;

    logic [XLEN-1:0] exp_q[$];
    logic [TAG_W-1:0] tag_q[$];
    int lat_q[$];
    int checks = 0;
    int failures = 0;

    rvr32_mdu #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] p;
        logic ovf;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            T_MUL:    begin p = sa * sb; return p[31:0]; end
            T_MULH:   begin p = sa * sb; return p[63:32]; end
            T_MULHSU: begin p = sa * $signed({32'b0, b}); return p[63:32]; end
            T_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            T_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            T_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            T_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return MUL_LAT;
        if (b == 0) return 1;
        if ((op == T_DIV || op == T_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 2;
    endfunction

    // Drives one request, returns at accept edge + 1ns after pushing the expectation.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input logic [31:0] exp_data);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        #1;
        while (!in_ready && guard < 200) begin
            @(negedge clk); #1; guard++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL issue_ready op=%0d got in_ready=%0b want 1", op, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(exp_data);
        tag_q.push_back(tag);
        lat_q.push_back(exp_lat(op, a, b));
    endtask

    // Waits for out_valid starting at accept + 1ns, then checks data, tag and latency.
    task automatic collect(input bit consume);
        int lat = 1;
        logic [XLEN-1:0] e;
        logic [TAG_W-1:0] t;
        int l;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (!out_valid || exp_q.size() == 0) begin
            failures++;
            $display("FAIL result_timeout got out_valid=%0b want 1 within 200 cycles", out_valid);
            exp_q.delete(); tag_q.delete(); lat_q.delete();
            return;
        end
        e = exp_q.pop_front(); t = tag_q.pop_front(); l = lat_q.pop_front();
        checks += 3;
        if (out_data !== e) begin
            failures++; $display("FAIL result_data got %h want %h", out_data, e);
        end
        if (out_tag !== t) begin
            failures++; $display("FAIL result_tag got %0d want %0d", out_tag, t);
        end
        if (lat != l) begin
            failures++; $display("FAIL result_latency got %0d want %0d", lat, l);
        end
        if (consume) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got %h want 0", out_data); end
        if (out_tag !== '0) begin failures++; $display("FAIL reset_out_tag got %0d want 0", out_tag); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        issue(T_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB); collect(1);
        issue(T_MULH,   32'h0000_0007, 32'hFFFF_FFFD, 5'd2, 32'hFFFF_FFFF); collect(1);
        issue(T_MULHU,  32'h0000_0007, 32'hFFFF_FFFD, 5'd3, 32'h0000_0006); collect(1);
        issue(T_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF); collect(1);
        issue(T_MULHU,  32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000); collect(1);
    endtask

    task automatic test_div();
        issue(T_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 5'd6, 32'hFFFF_FFFD); collect(1);
        issue(T_REM,  32'hFFFF_FFF9, 32'h0000_0002, 5'd7, 32'hFFFF_FFFF); collect(1);
        issue(T_DIVU, 32'hFFFF_FFFE, 32'h0000_0002, 5'd8, 32'h7FFF_FFFF); collect(1);
    endtask

    task automatic test_special();
        issue(T_DIV,  32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF); collect(1);
        issue(T_REMU, 32'd5,         32'd0,         5'd10, 32'd5);         collect(1);
        issue(T_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000); collect(1);
        issue(T_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0);         collect(1);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        out_ready = 1'b0;
        issue(T_MUL, 32'd3, 32'd5, 5'd9, 32'd15);
        collect(0);
        repeat (5) begin
            @(posedge clk); #1;
            checks += 4;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_valid got %0b want 1", out_valid); end
            if (out_data !== 32'd15) begin failures++; $display("FAIL hold_data got %h want 0000000f", out_data); end
            if (out_tag !== 5'd9) begin failures++; $display("FAIL hold_tag got %0d want 9", out_tag); end
            if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready got %0b want 0", in_ready); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = T_DIVU; in_a = 32'hFFFF_FFFE; in_b = 32'd2; in_tag = 5'd3;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got %0b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(32'h7FFF_FFFF); tag_q.push_back(5'd3); lat_q.push_back(XLEN + 2);
        checks++;
        if (dbg_state !== ST_DIV) begin failures++; $display("FAIL release_accept got state %0d want %0d", dbg_state, ST_DIV); end
        collect(1);
    endtask

    task automatic test_flush();
        bit seen = 0;
        issue(T_DIV, 32'hFFFF_FF9C, 32'd7, 5'd4, 32'hFFFF_FFF2);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1; in_op = T_MUL; in_a = 32'd2; in_b = 32'd3; in_tag = 5'd20;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got %0b want 0", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got %0b want 0", out_valid); end
        if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL flush_state got %0d want %0d", dbg_state, ST_IDLE); end
        exp_q.delete(); tag_q.delete(); lat_q.delete();
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        checks++;
        if (seen) begin failures++; $display("FAIL flush_no_result got out_valid=1 want 0"); end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                default: ;
            endcase
            issue(op, a, b, 5'($urandom_range(0, 31)), ref_mdu(op, a, b));
            collect(1);
        end
    endtask

    task automatic test_reset_mid();
        issue(T_MUL, 32'd7, 32'd9, 5'd17, 32'd63);
        collect(1);
        issue(T_MUL, 32'd11, 32'd13, 5'd18, 32'd143);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks += 5;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got %0b want 0", out_valid); end
        if (out_data !== '0) begin failures++; $display("FAIL midreset_out_data got %h want 0", out_data); end
        if (out_tag !== '0) begin failures++; $display("FAIL midreset_out_tag got %0d want 0", out_tag); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready got %0b want 1", in_ready); end
        if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL midreset_state got %0d want 0", dbg_state); end
        exp_q.delete(); tag_q.delete(); lat_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(T_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21, 32'hFFFF_FFFE);
        collect(1);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_flush();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
